// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, legal-opcode limit and the
// arbiter FSM state type.
package alu_pkg;

  localparam int OP_W         = 4;
  localparam int OP_LEGAL_MAX = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLT = 4'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  function automatic logic op_legal(input int unsigned op);
    return op <= OP_LEGAL_MAX;
  endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle combinational ALU shared by the requesters behind alu_arbiter.
// Illegal opcodes produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] operand1,
  input  logic [DATA_W-1:0] operand2,
  input  logic [OP_W-1:0]   ALUControl,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (ALUControl)
      OP_ADD:  result = operand1 + operand2;
      OP_SUB:  result = operand1 - operand2;
      OP_AND:  result = operand1 & operand2;
      OP_OR:   result = operand1 | operand2;
      OP_XOR:  result = operand1 ^ operand2;
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr,
// wrapping, and returns it as a one-hot grant plus its index.
module rr_arbiter #(
  parameter  int N     = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters: round-robin grant,
// registered ALU inputs, captured result returned on a per-requester handshake.
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int OP_W    = alu_pkg::OP_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         alu_operand1,
  output logic [DATA_W-1:0]         alu_operand2,
  output logic [OP_W-1:0]           alu_control,
  input  logic [DATA_W-1:0]         alu_result,
  output logic                      busy
);
  import alu_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e         state, state_d;
  logic [IDX_W-1:0]   rr_ptr, gnt_idx;
  logic [NUM_REQ-1:0] gnt_q;
  logic               illegal_q;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [OP_W-1:0]    sel_op;
  logic [DATA_W-1:0]  sel_a, sel_b;
  logic               accept, rsp_hs;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_op = req_op[i*OP_W +: OP_W];
        sel_a  = req_a[i*DATA_W +: DATA_W];
        sel_b  = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    rsp_hs  = 1'b0;
    case (state)
      ST_IDLE: if (arb_any) begin
        accept  = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_RESP;
      // only the granted requester's rsp_ready can complete the response
      ST_RESP: if (|(rsp_ready & gnt_q)) begin
        rsp_hs  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      gnt_idx      <= '0;
      gnt_q        <= '0;
      illegal_q    <= 1'b0;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      alu_control  <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
    end else begin
      if (accept) begin
        gnt_idx   <= arb_idx;
        gnt_q     <= arb_grant;
        illegal_q <= !op_legal(32'(sel_op));
        // an illegal opcode leaves the ALU inputs at their previous values
        if (op_legal(32'(sel_op))) begin
          alu_operand1 <= sel_a;
          alu_operand2 <= sel_b;
          alu_control  <= sel_op;
        end
      end
      if (state == ST_EXEC) begin
        rsp_data <= illegal_q ? '0 : alu_result;
        rsp_err  <= illegal_q;
      end
      if (rsp_hs)
        rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

  // rst_n gate keeps req_ready low while reset is held with requests pending
  assign req_ready = (state == ST_IDLE && rst_n) ? arb_grant : '0;
  assign rsp_valid = (state == ST_RESP) ? gnt_q : '0;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter with the real ALU alongside: table-driven vectors,
// hand sequences for arbitration, backpressure and reset, and a scoreboard.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam int OW = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [NR*OW-1:0] req_op = '0;
  logic [NR*DW-1:0] req_a = '0;
  logic [NR*DW-1:0] req_b = '0;
  logic [NR-1:0]    rsp_valid;
  logic [NR-1:0]    rsp_ready = '1;
  logic [DW-1:0]    rsp_data;
  logic             rsp_err;
  logic [DW-1:0]    alu_operand1, alu_operand2, alu_result;
  logic [OW-1:0]    alu_control;
  logic             busy;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_control(alu_control), .alu_result(alu_result),
    .busy(busy)
  );

  alu #(.DATA_W(DW)) u_alu (
    .operand1(alu_operand1), .operand2(alu_operand2),
    .ALUControl(alu_control), .result(alu_result)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference ALU behaviour: {err, data}
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return {1'b0, a + b};
      4'd1:    return {1'b0, a - b};
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, a ^ b};
      4'd5:    return {1'b0, 31'd0, ($signed(a) < $signed(b))};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        err;
  } sb_t;
  sb_t sb[$];

  // Scoreboard: push on request handshake, pop on response handshake
  sb_t         t;
  logic [32:0] m;
  always @(negedge clk) begin
    if (!rst_n) sb.delete();
    else begin
      for (int i = 0; i < NR; i++)
        if (req_valid[i] && req_ready[i]) begin
          m = model(req_op[i*OW +: OW], req_a[i*DW +: DW], req_b[i*DW +: DW]);
          sb.push_back('{idx: i, data: m[31:0], err: m[32]});
        end
      if (|(rsp_valid & rsp_ready)) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_underflow: response %b with no request outstanding", rsp_valid);
        end else begin
          t = sb.pop_front();
          check("sb_idx",  32'(rsp_valid), 32'(NR'(1) << t.idx));
          check("sb_data", rsp_data, t.data);
          check("sb_err",  32'(rsp_err), 32'(t.err));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[r*OW +: OW] = op;
    req_a[r*DW +: DW]  = a;
    req_b[r*DW +: DW]  = b;
  endtask

  task automatic wait_accept(output logic [NR-1:0] g);
    g = '0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) begin
        g = req_ready;
        break;
      end
    end
    if (g == '0) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: no req_ready within 30 cycles");
    end
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: busy still high after 30 cycles");
    end
  endtask

  typedef struct {
    int          r;
    logic [3:0]  op;
    logic [31:0] a, b, d;
    logic        e;
  } vec_t;

  // Single request with cycle-exact checks: accept N, EXEC N+1, response N+2
  task automatic run_vec(input vec_t v);
    logic [NR-1:0] g;
    cyc();
    set_req(v.r, v.op, v.a, v.b);
    req_valid = NR'(1) << v.r;
    wait_accept(g);
    check("vec_grant", 32'(g), 32'(NR'(1) << v.r));
    cyc();
    req_valid = '0;
    @(negedge clk);
    check("vec_ready_n1", 32'(req_ready), 0);
    check("vec_busy_n1",  32'(busy), 1);
    check("vec_rspv_n1",  32'(rsp_valid), 0);
    @(negedge clk);
    check("vec_ready_n2", 32'(req_ready), 0);
    check("vec_rspv_n2",  32'(rsp_valid), 32'(NR'(1) << v.r));
    check("vec_data",     rsp_data, v.d);
    check("vec_err",      32'(rsp_err), 32'(v.e));
    wait_idle();
  endtask

  // Both requesters valid together: check who wins first and its result
  task automatic run_pair(input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                          input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                          input logic [NR-1:0] first, input logic [31:0] d_first);
    logic [NR-1:0] g, g2, other;
    other = ~first;
    cyc();
    set_req(0, op0, a0, b0);
    set_req(1, op1, a1, b1);
    req_valid = '1;
    wait_accept(g);
    check("pair_first", 32'(g), 32'(first));
    cyc();
    req_valid = req_valid & ~g;
    @(negedge clk);
    check("pair_ready_n1", 32'(req_ready), 0);
    @(negedge clk);
    check("pair_rspv_n2", 32'(rsp_valid), 32'(first));
    check("pair_data_n2", rsp_data, d_first);
    wait_accept(g2);
    check("pair_second", 32'(g2), 32'(other));
    cyc();
    req_valid = '0;
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[10];
  logic [NR-1:0] g;

  initial begin
    tbl[0] = '{r: 0, op: 4'd0, a: 32'h1,        b: 32'h2,        d: 32'h3,        e: 1'b0};
    tbl[1] = '{r: 1, op: 4'd1, a: 32'h0,        b: 32'h1,        d: 32'hFFFFFFFF, e: 1'b0};
    tbl[2] = '{r: 0, op: 4'd0, a: 32'hFFFFFFFF, b: 32'h1,        d: 32'h0,        e: 1'b0};
    tbl[3] = '{r: 1, op: 4'd2, a: 32'hF0F0F0F0, b: 32'hFF00FF00, d: 32'hF000F000, e: 1'b0};
    tbl[4] = '{r: 0, op: 4'd3, a: 32'h00001234, b: 32'h56780000, d: 32'h56781234, e: 1'b0};
    tbl[5] = '{r: 1, op: 4'd5, a: 32'hFFFFFFFF, b: 32'h1,        d: 32'h1,        e: 1'b0};
    tbl[6] = '{r: 0, op: 4'd5, a: 32'h1,        b: 32'hFFFFFFFF, d: 32'h0,        e: 1'b0};
    tbl[7] = '{r: 1, op: 4'd5, a: 32'h80000000, b: 32'h7FFFFFFF, d: 32'h1,        e: 1'b0};
    tbl[8] = '{r: 0, op: 4'd6, a: 32'h11,       b: 32'h22,       d: 32'h0,        e: 1'b1};
    tbl[9] = '{r: 1, op: 4'd4, a: 32'hFFFF0000, b: 32'h0F0F0F0F, d: 32'hF0F00F0F, e: 1'b0};

    // reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data",  rsp_data, 0);
    check("rst_rsp_err",   32'(rsp_err), 0);
    check("rst_op1",       alu_operand1, 0);
    check("rst_op2",       alu_operand2, 0);
    check("rst_ctl",       32'(alu_control), 0);
    check("rst_busy",      32'(busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // simultaneous from reset: req0 first, then req1, pointer back to 0
    run_pair(4'd1, 32'd3, 32'd2, 4'd2, 32'hF0, 32'hF00, 2'b01, 32'd1);

    // both continuously valid: strict alternation
    cyc();
    set_req(0, 4'($urandom_range(0, 5)), $urandom, $urandom);
    set_req(1, 4'($urandom_range(0, 5)), $urandom, $urandom);
    req_valid = '1;
    for (int n = 0; n < 12; n++) begin
      wait_accept(g);
      check("alt_grant", 32'(g), 32'(NR'(1) << (n % NR)));
      cyc();
      for (int i = 0; i < NR; i++)
        if (g[i]) set_req(i, 4'($urandom_range(0, 5)), $urandom, $urandom);
    end
    req_valid = '0;
    wait_idle();

    for (int n = 0; n < 10; n++) run_vec(tbl[n]);

    // backpressure on req1 for 4 cycles, req0 pending and ignored meanwhile
    cyc();
    rsp_ready = 2'b01;
    set_req(1, 4'd3, 32'hAAAAAAAA, 32'h55555555);
    req_valid = 2'b10;
    wait_accept(g);
    check("bp_grant", 32'(g), 32'h2);
    cyc();
    req_valid = 2'b01;
    @(negedge clk);
    check("bp_ready_n1", 32'(req_ready), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_rspv",  32'(rsp_valid), 32'h2);
      check("bp_data",  rsp_data, 32'hFFFFFFFF);
      check("bp_err",   32'(rsp_err), 0);
      check("bp_ready", 32'(req_ready), 0);
    end
    cyc();
    rsp_ready = '1;
    req_valid = '0;
    @(negedge clk);
    check("bp_rspv_release", 32'(rsp_valid), 32'h2);
    wait_idle();

    // illegal opcode leaves the XOR operands on the ALU
    run_vec('{r: 0, op: 4'd4, a: 32'h12345678, b: 32'h56781234, d: 32'h444C444C, e: 1'b0});
    run_vec('{r: 0, op: 4'hF, a: 32'hDEADBEEF, b: 32'hCAFEF00D, d: 32'h0, e: 1'b1});
    check("ill_op1", alu_operand1, 32'h12345678);
    check("ill_op2", alu_operand2, 32'h56781234);
    check("ill_ctl", 32'(alu_control), 32'h4);

    // reset during EXEC; pointer was 1 and must return to 0
    cyc();
    set_req(0, 4'd5, 32'd1, 32'd2);
    req_valid = 2'b01;
    wait_accept(g);
    cyc();
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rspv",  32'(rsp_valid), 0);
    check("mid_rst_data",  rsp_data, 0);
    check("mid_rst_err",   32'(rsp_err), 0);
    check("mid_rst_op1",   alu_operand1, 0);
    check("mid_rst_op2",   alu_operand2, 0);
    check("mid_rst_ctl",   32'(alu_control), 0);
    check("mid_rst_busy",  32'(busy), 0);
    check("mid_rst_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_rspv", 32'(rsp_valid), 0);
      check("post_rst_busy", 32'(busy), 0);
    end
    run_pair(4'd0, 32'd5, 32'd7, 4'd1, 32'd9, 32'd4, 2'b01, 32'd12);

    check("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle combinational ALU (operand1/operand2/ALUControl → result) between NUM_REQ requesters. Arbitrates round-robin, registers the winning request onto the ALU inputs, captures the result, and returns it on a per-requester response handshake. Sits between the requesting engines and the ALU instance; the ALU is instantiated at the parent level and connected through the `alu_*` ports.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- DATA_W, 32, operand/result width
- OP_W, 4, ALU control width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  request valid, one bit per requester
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- req_op  in  NUM_REQ*OP_W  ALU opcode, requester i at [i*OP_W +: OP_W]
- req_a  in  NUM_REQ*DATA_W  operand1 per requester
- req_b  in  NUM_REQ*DATA_W  operand2 per requester
- rsp_valid  out  NUM_REQ  response valid, one-hot or zero
- rsp_ready  in  NUM_REQ  response accepted by requester
- rsp_data  out  DATA_W  result, qualified by rsp_valid
- rsp_err  out  1  illegal opcode flag, qualified by rsp_valid
- alu_operand1  out  DATA_W  to ALU operand1
- alu_operand2  out  DATA_W  to ALU operand2
- alu_control  out  OP_W  to ALU ALUControl
- alu_result  in  DATA_W  from ALU result
- busy  out  1  high in EXEC or RESP

## Operation
- Legal opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT; 6..15 illegal.
- FSM IDLE → EXEC → RESP → IDLE.
- IDLE: if any req_valid, grant = first requester with req_valid at or after rr_ptr (wrapping). req_ready[grant]=1 combinationally in this cycle only; latch op/a/b into alu_* registers, latch grant index; go EXEC. req_ready is 0 in all other states.
- EXEC: alu_* outputs stable; at cycle end capture alu_result into rsp_data, rsp_err=0; go RESP.
- Illegal opcode at accept: alu_* registers not updated (ALU inputs hold previous values); EXEC captures rsp_data=0, rsp_err=1.
- RESP: rsp_valid[grant]=1, rsp_data/rsp_err held stable until rsp_ready[grant]; on handshake clear rsp_valid, rr_ptr = (grant+1) mod NUM_REQ, go IDLE.
- rsp_ready of non-granted requesters ignored.
- req_valid withdrawn before req_ready: no transaction, no pointer change.

## Timing
- Reset: state IDLE, rr_ptr 0, all outputs 0 (req_ready, rsp_valid, rsp_data, rsp_err, alu_operand1/2, alu_control, busy).
- Accept in cycle N → alu_* valid from N+1 → rsp_valid rises at N+2.
- rsp_ready already high at N+2 → handshake in N+2, IDLE at N+3, next accept earliest N+3. Peak throughput 1 op / 3 cycles.
- Backpressure: each cycle rsp_ready low extends RESP by one cycle; no new grant meanwhile.
- Simultaneous requests: strict rotation; with all requesters continuously valid, grants cycle 0,1,…,NUM_REQ-1,0.
- Reset mid-operation (EXEC/RESP): transaction dropped, no response issued, rr_ptr back to 0.
- No combinational path from req_* or alu_result to any output except req_ready (depends on req_valid, state, rr_ptr).

## Structure
- Shared package `alu_pkg`: opcode enum (ADD..SLT), OP_W, legal-opcode limit constant, FSM state typedef.
- One sub-module: `rr_arbiter` (NUM_REQ request vector + pointer → one-hot grant and index), reusable elsewhere.
- Bench instantiates the real ALU beside alu_arbiter.

## Test plan
- Req0 ADD a=1 b=2 accepted cycle N, rsp_ready high → rsp_valid[0] at N+2, rsp_data=3, rsp_err=0; req_ready low N+1..N+2.
- Req0 and Req1 valid together from reset (Req0 SUB 3,2; Req1 AND 0xF0,0xF00) → Req0 served first (data 1), Req1 accepted at next IDLE (data 0); rr_ptr returns to 0.
- Req1 OR 0xAAAAAAAA,0x55555555 with rsp_ready[1] held low 4 cycles → rsp_valid[1] and rsp_data=0xFFFFFFFF stable all 4 cycles; no req_ready pulses.
- Req0 opcode 4'hF after a prior XOR 0x12345678^0x56781234 → rsp_err=1, rsp_data=0; alu_operand1/2/control unchanged from XOR values.
- rst_n asserted during EXEC of SLT 1,2 → all outputs 0 immediately; after release, no stale rsp_valid; new ADD 5,7 returns 12 at N+2.
- Both requesters continuously valid for 12 transactions → grants alternate 0,1,0,1…; every response matches its requester's operands.
